// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR fetch stage with 64-word instruction memory, IDLE/RUN/HALT control.
module instr_fetch_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWre,
    input  logic        IRWre,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] immediate,
    input  logic [25:0] jaddr,
    input  logic        imem_we,
    input  logic [7:0]  imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] curPC,
    output logic [31:0] nextPC,
    output logic [31:0] iDataOut,
    output logic [31:0] irPC,
    output logic        valid,
    output logic        halted,
    output logic [15:0] fetch_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state, state_nxt;
    logic [31:0] mem [64];
    logic [31:0] pc4, instr;
    logic capture, halt_cap, unused;

    assign unused = ^imem_waddr[1:0];
    assign instr = mem[curPC[7:2]];
    assign pc4 = curPC + 32'd4;
    assign nextPC = PCSrc == 2'b00 ? pc4 :
                    PCSrc == 2'b01 ? pc4 + {{14{immediate[15]}}, immediate, 2'b00} :
                    PCSrc == 2'b10 ? {pc4[31:28], jaddr, 2'b00} : curPC;
    assign capture = state == RUN && IRWre;
    assign halt_cap = capture && instr[31:26] == 6'b111111;
    assign halted = state == HALT;

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? RUN : halt_cap ? HALT : state;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else state <= state_nxt;
    end

    // A halting capture still loads IR but pins the PC at the halt instruction
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            curPC <= '0;
            iDataOut <= '0;
            irPC <= '0;
            valid <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (state == RUN && PCWre && !halt_cap) curPC <= nextPC;
            if (capture) begin
                iDataOut <= instr;
                irPC <= curPC;
                valid <= 1'b1;
                if (fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
            end
        end
    end

    // Preload port is independent of reset and state; nonblocking write gives read-before-write
    always_ff @(posedge CLK) begin
        if (imem_we) mem[imem_waddr[7:2]] <= imem_wdata;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench with a spec-level fetch model.
module tb_instr_fetch_unit;
    logic        CLK = 0, RST = 0, PCWre = 0, IRWre = 0, imem_we = 0;
    logic [1:0]  PCSrc = 0;
    logic [15:0] immediate = 0;
    logic [25:0] jaddr = 0;
    logic [7:0]  imem_waddr = 0;
    logic [31:0] imem_wdata = 0;
    logic [31:0] curPC, nextPC, iDataOut, irPC;
    logic        valid, halted;
    logic [15:0] fetch_cnt;

    instr_fetch_unit dut (
        .CLK(CLK), .RST(RST), .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc),
        .immediate(immediate), .jaddr(jaddr), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .curPC(curPC),
        .nextPC(nextPC), .iDataOut(iDataOut), .irPC(irPC), .valid(valid),
        .halted(halted), .fetch_cnt(fetch_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc, npc, ir, irpc;
        logic        v, h;
        logic [15:0] cnt;
    } exp_t;
    exp_t q[$];

    logic [31:0] mm [64];
    logic [31:0] m_pc = 0, m_ir = 0, m_irpc = 0;
    logic        m_v = 0, m_h = 0, m_bub = 1;
    logic [15:0] m_cnt = 0;
    int checks = 0, fails = 0;

    function automatic logic [31:0] npc_f(input logic [31:0] pc, input logic [1:0] src,
                                          input logic [15:0] imm, input logic [25:0] ja);
        logic [31:0] s;
        logic signed [31:0] off;
        s = pc + 32'd4;
        off = 32'(signed'(imm));
        if (src == 2'd0) return s;
        if (src == 2'd1) return s + 32'(off * 4);
        if (src == 2'd2) return (s & 32'hF000_0000) | (32'(ja) * 32'd4);
        return pc;
    endfunction

    function automatic logic [31:0] rw();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'b111111) w[26] = 1'b0;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] w;
        logic halting;
        halting = 0;
        if (m_bub) m_bub = 0;
        else if (!m_h) begin
            if (IRWre) begin
                w = mm[m_pc[7:2]];
                m_ir = w;
                m_irpc = m_pc;
                m_v = 1;
                if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (w[31:26] == 6'b111111) begin
                    m_h = 1;
                    halting = 1;
                end
            end
            if (PCWre && !halting) m_pc = npc_f(m_pc, PCSrc, immediate, jaddr);
        end
        if (imem_we) mm[imem_waddr[7:2]] = imem_wdata;
        q.push_back('{pc: m_pc, npc: npc_f(m_pc, PCSrc, immediate, jaddr), ir: m_ir,
                      irpc: m_irpc, v: m_v, h: m_h, cnt: m_cnt});
    endtask

    task automatic cycle(input logic pw, input logic iw, input logic [1:0] src,
                         input logic [15:0] imm, input logic [25:0] ja, input logic we,
                         input logic [7:0] wa, input logic [31:0] wd);
        @(negedge CLK);
        PCWre = pw; IRWre = iw; PCSrc = src; immediate = imm; jaddr = ja;
        imem_we = we; imem_waddr = wa; imem_wdata = wd;
        if (RST) model_step();
        else if (we) mm[wa[7:2]] = wd;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_curPC"}, curPC, 0);
        chk({tag, "_ir"}, iDataOut, 0);
        chk({tag, "_irPC"}, irPC, 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_halted"}, 32'(halted), 0);
        chk({tag, "_cnt"}, 32'(fetch_cnt), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        imem_we = 0;
        #2;
        RST = 0;
        m_pc = 0; m_ir = 0; m_irpc = 0; m_v = 0; m_h = 0; m_cnt = 0; m_bub = 1;
        #1;
        check_zero(tag);
    endtask

    task automatic rel();
        @(negedge CLK);
        RST = 1; PCWre = 0; IRWre = 0; imem_we = 0;
        model_step();
    endtask

    task automatic rnd_cycle();
        cycle(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 26'($urandom),
              $urandom_range(0, 7) == 0, 8'($urandom_range(16, 255)), rw());
    endtask

    // Monitor: compares the DUT against the oldest expectation after each edge
    initial forever begin
        exp_t e;
        @(posedge CLK);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_curPC", curPC, e.pc);
            chk("sb_nextPC", nextPC, e.npc);
            chk("sb_ir", iDataOut, e.ir);
            chk("sb_irPC", irPC, e.irpc);
            chk("sb_valid", 32'(valid), 32'(e.v));
            chk("sb_halted", 32'(halted), 32'(e.h));
            chk("sb_cnt", 32'(fetch_cnt), 32'(e.cnt));
        end
    end

    initial begin
        logic [31:0] seqw [4];
        seqw[0] = 32'h11111111; seqw[1] = 32'h22222222;
        seqw[2] = 32'h33333333; seqw[3] = 32'h44444444;
        #3;
        check_zero("por");
        for (int i = 0; i < 64; i++)
            cycle(0, 0, 0, 0, 0, 1, {6'(i), 2'($urandom)}, i < 4 ? seqw[i] : rw());
        rel();
        repeat (6) cycle(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (400) rnd_cycle();

        do_reset("rst_run");
        rel();
        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 16'hFFFE, 0, 0, 0, 0);
        #1 chk("branch_npc", nextPC, 32'h4);
        @(posedge CLK);
        #1 chk("branch_pc", curPC, 32'h4);
        repeat (3) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1 chk("stall_cnt", 32'(fetch_cnt), 3);
        chk("stall_pc", curPC, 32'h4);
        chk("stall_ir", iDataOut, 32'h22222222);

        while (m_pc[31:28] != 4'hF) begin
            if (m_pc[27:0] == 28'hFFFFFFC) cycle(1, 1, 0, 0, 0, 0, 0, 0);
            else cycle(1, 1, 2, 0, 26'h3FFFFFF, 0, 0, 0);
        end
        cycle(1, 1, 2, 0, 26'h3F, 0, 0, 0);
        cycle(0, 0, 2, 0, 26'h10, 0, 0, 0);
        #1 chk("jump_npc", nextPC, 32'hF0000040);
        chk("jump_pc", curPC, 32'hF00000FC);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1 chk("wrap_ir", iDataOut, 32'h11111111);
        chk("wrap_irPC", irPC, 32'hF0000100);

        repeat (65540) cycle(0, 1, 3, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1 chk("sat_cnt", 32'(fetch_cnt), 32'hFFFF);

        do_reset("rst_sat");
        cycle(0, 0, 0, 0, 0, 1, 8'h08, 32'hFC000000);
        rel();
        repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1 chk("halt_flag", 32'(halted), 1);
        chk("halt_pc", curPC, 32'h8);
        chk("halt_ir", iDataOut, 32'hFC000000);
        repeat (8) rnd_cycle();
        do_reset("rst_halt");
        rel();
        repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1 chk("mem_kept_ir", iDataOut, 32'hFC000000);
        chk("mem_kept_halt", 32'(halted), 1);
        chk("mem_kept_cnt", 32'(fetch_cnt), 3);

        repeat (2) @(posedge CLK);
        #3 chk("sb_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
